rtc_scan_sequencer: RTL and testbench
=====================================

# rtc_scan_sequencer

- Parametrised read-address sequencer for the RTC register scan.
- While a read phase is active, it walks an address list built from two contiguous segments. Each address is held for a programmable dwell time, and the block emits a sample strobe when the data should be captured.
- Sits between the read/write control logic and the RTC bus interface. It replaces the fixed 11-address scanner.
- Over the fixed scanner it adds: configurable segments and dwell, single-pass mode, pause, and index/strobe/done outputs.

## Interface
Parameters:
- ADDR_W, 8: address bus width.
- SEG0_BASE, 8'h21: first address of segment 0.
- SEG0_LEN, 8: number of addresses in segment 0; legal range 1..16.
- SEG1_BASE, 8'h41: first address of segment 1.
- SEG1_LEN, 3: number of addresses in segment 1; legal range 0..16. 0 disables segment 1.
- DWELL, 74: active cycles per address; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rw  in  1  read phase flag. Low clears the scan.
- per_read  in  1  read permission. Low freezes the scan.
- pause  in  1  holds the current address and dwell count while high.
- single  in  1  selects the pass mode: 1 = single pass, 0 = continuous loop. Sampled only on entry to SCAN.
- address  out  ADDR_W  current register address.
- addr_valid  out  1  high while address carries a scan address.
- index  out  IDX_W  position in the list, 0..N-1. N = SEG0_LEN+SEG1_LEN; IDX_W = $clog2(N+1).
- sample  out  1  one-cycle strobe on the last dwell cycle of each address.
- pass_done  out  1  one-cycle pulse coincident with sample of index N-1.

## Operation
- Let active = rw & per_read & !pause.
- Address map: index i < SEG0_LEN gives SEG0_BASE+i. Otherwise it gives SEG1_BASE+(i-SEG0_LEN). Addition is mod 2^ADDR_W.
- States:
  - IDLE: outputs idle. Enter SCAN when rw & per_read; index = 0, dwell count = 0, and the single-mode flag is latched.
  - SCAN: address and addr_valid are registered from index.
    - Dwell counter increments on each active cycle.
    - At count DWELL-1: sample = 1, count returns to 0, index advances.
    - At index N-1 with sample, pass_done = 1. Continuous mode then wraps index to 0. Single mode goes to DONE.
  - DONE: idle outputs; index holds N-1. Stays in DONE until rw falls.
- rw low in any state: go to IDLE next edge; clear index and count; address idle; strobes 0.
- per_read low with rw high:
  - State, index and count hold.
  - address goes idle and addr_valid is 0.
  - Scanning resumes at the same index and count when per_read returns.
- pause high during SCAN: address and addr_valid stay driven; count and index hold; no strobes.
- Idle address value: see Configuration.
- index is always registered, including in IDLE (0) and DONE (N-1).

## Timing
- Reset values: address = idle value, addr_valid = 0, index = 0, sample = 0, pass_done = 0, state = IDLE.
- Entry latency: address valid on the first edge after rw & per_read is sampled high.
  - That edge is dwell cycle 0; sample asserts on the DWELL-th active edge.
- Each address is driven for exactly DWELL active cycles; pause and frozen cycles extend it.
- sample and pass_done are high for one cycle only, and only when active.
- The new address appears the cycle after sample.
- rw dropping on a sample cycle: the strobe for that cycle is still issued (registered from the prior state); next cycle is IDLE.
- Asynchronous reset mid-scan forces reset values immediately; the scan restarts at index 0.

## Configuration
- RTC_SCAN_TRISTATE_EN defined: the idle address value is all-Z, so address can share a bus.
- Undefined: the idle address value is all-zero, for purely internal use.
- All other behaviour is identical in both builds.

## Test plan
- Defaults, continuous, rw = per_read = 1 for 2000 cycles:
  - Expect 21,22,…,28,41,42,43,21,… each held 74 cycles.
  - sample every 74 cycles; pass_done every 814 cycles.
- single = 1, defaults:
  - Exactly one pass of 11 addresses, then one pass_done.
  - Then addr_valid = 0 and the address is idle until rw toggles.
  - Then the scan restarts at 8'h21.
- pause high for 10 cycles at dwell count 30 of address 8'h24:
  - 8'h24 is held for 84 cycles total.
  - No sample during the pause.
- per_read low for 20 cycles at index 5:
  - address idle and addr_valid 0 during the gap.
  - 8'h26 resumes with the remaining dwell.
- rw low at index 9, then high:
  - Restart at 8'h21 with a full 74-cycle dwell.
- Async reset mid-dwell at index 3: all outputs at reset values without waiting for a clock edge.
- Parameter variant DWELL = 2, SEG1_LEN = 0, SEG0_LEN = 4, SEG0_BASE = 8'hFE:
  - Expect FE,FF,00,01 wrap, each held 2 cycles.
  - Both builds: idle address Z with RTC_SCAN_TRISTATE_EN, 0 without.

Source files
------------

// File: rtl/rtc_scan_sequencer.sv
// RTC register scan sequencer: walks two contiguous address segments, holding each for DWELL active cycles.
// Build option RTC_SCAN_TRISTATE_EN: idle address floats (all-Z) instead of driving zero.
module rtc_scan_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] SEG0_BASE = 8'h21,
  parameter int                SEG0_LEN  = 8,
  parameter logic [ADDR_W-1:0] SEG1_BASE = 8'h41,
  parameter int                SEG1_LEN  = 3,
  parameter int                DWELL     = 74,
  localparam int               N         = SEG0_LEN + SEG1_LEN,
  localparam int               IDX_W     = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rw,
  input  logic              per_read,
  input  logic              pause,
  input  logic              single,
  output logic [ADDR_W-1:0] address,
  output logic              addr_valid,
  output logic [IDX_W-1:0]  index,
  output logic              sample,
  output logic              pass_done
);

  localparam int               CNT_W    = $clog2(DWELL);
  localparam logic [IDX_W-1:0] SEG0_END = IDX_W'(SEG0_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DWELL - 2);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t            r_state, w_state_n;
  logic [IDX_W-1:0]  r_index, w_index_n;
  logic [CNT_W-1:0]  r_count, w_count_n;
  logic [ADDR_W-1:0] r_address, w_addr_n;
  logic              r_addr_valid, w_valid_n;
  logic              r_sample, w_sample_n;
  logic              r_pass_done, w_done_n;
  logic              r_single, w_single_n;
  logic              w_active, w_last, w_adv;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    if (idx < SEG0_END) addr_of = SEG0_BASE + ADDR_W'(idx);
    else                addr_of = SEG1_BASE + ADDR_W'(idx - SEG0_END);
  endfunction

  assign w_active = rw & per_read & ~pause;
  assign w_last   = (r_index == LAST_IDX);
  assign w_adv    = (r_state == S_SCAN) & w_active & (r_count == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    if (!rw) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (per_read) w_state_n = S_SCAN;
        S_SCAN:  if (w_adv && w_last && r_single) w_state_n = S_DONE;
        S_DONE:  w_state_n = S_DONE;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; index is kept cycle-aligned with address.
  always_comb begin
    w_index_n  = r_index;
    w_count_n  = r_count;
    w_addr_n   = r_address;
    w_valid_n  = 1'b0;
    w_sample_n = 1'b0;
    w_done_n   = 1'b0;
    w_single_n = r_single;
    if (!rw) begin
      w_index_n = '0;
      w_count_n = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (per_read) begin
            w_index_n  = '0;
            w_count_n  = '0;
            w_single_n = single;
            w_addr_n   = addr_of('0);
            w_valid_n  = 1'b1;
          end
        end
        S_SCAN: begin
          if (per_read) begin
            w_valid_n = 1'b1;
            w_addr_n  = addr_of(r_index);
            if (!pause) begin
              if (r_count == CNT_LAST) begin
                w_count_n = '0;
                if (!w_last) begin
                  w_index_n = r_index + IDX_W'(1);
                  w_addr_n  = addr_of(r_index + IDX_W'(1));
                end else if (r_single) begin
                  w_valid_n = 1'b0;
                end else begin
                  w_index_n = '0;
                  w_addr_n  = addr_of('0);
                end
              end else begin
                w_count_n  = r_count + CNT_W'(1);
                w_sample_n = (r_count == CNT_PRE);
                w_done_n   = (r_count == CNT_PRE) && w_last;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index      <= '0;
      r_count      <= '0;
      r_address    <= '0;
      r_addr_valid <= 1'b0;
      r_sample     <= 1'b0;
      r_pass_done  <= 1'b0;
      r_single     <= 1'b0;
    end else begin
      r_index      <= w_index_n;
      r_count      <= w_count_n;
      r_address    <= w_addr_n;
      r_addr_valid <= w_valid_n;
      r_sample     <= w_sample_n;
      r_pass_done  <= w_done_n;
      r_single     <= w_single_n;
    end
  end

`ifdef RTC_SCAN_TRISTATE_EN
  assign address = r_addr_valid ? r_address : {ADDR_W{1'bz}};
`else
  assign address = r_addr_valid ? r_address : '0;
`endif
  assign addr_valid = r_addr_valid;
  assign index      = r_index;
  assign sample     = r_sample;
  assign pass_done  = r_pass_done;

endmodule

// File: tb/tb_rtc_scan_sequencer.sv
// Directed bench for rtc_scan_sequencer: default configuration plus a short wrapping variant (DWELL=2).
module tb_rtc_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset, rw, per_read, pause, single;
  logic [7:0] address;
  logic       addr_valid;
  logic [3:0] index;
  logic       sample, pass_done;
  logic [7:0] addressV;
  logic       addrValidV;
  logic [2:0] indexV;
  logic       sampleV, passDoneV;

  int         checks = 0;
  int         passed = 0;
  int         fails  = 0;
  logic [7:0] idleAddr;
  logic [7:0] scanList [11];
  logic [7:0] variantList [4];

  always #5 clk = ~clk;

  rtc_scan_sequencer dut (
    .clk(clk), .reset(reset), .rw(rw), .per_read(per_read), .pause(pause), .single(single),
    .address(address), .addr_valid(addr_valid), .index(index), .sample(sample), .pass_done(pass_done)
  );

  rtc_scan_sequencer #(
    .ADDR_W(8), .SEG0_BASE(8'hFE), .SEG0_LEN(4), .SEG1_BASE(8'h41), .SEG1_LEN(0), .DWELL(2)
  ) dutVariant (
    .clk(clk), .reset(reset), .rw(rw), .per_read(per_read), .pause(pause), .single(single),
    .address(addressV), .addr_valid(addrValidV), .index(indexV), .sample(sampleV), .pass_done(passDoneV)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rwV, input logic prV, input logic pauseV, input logic singleV);
    rw       = rwV;
    per_read = prV;
    pause    = pauseV;
    single   = singleV;
  endtask

  // Restart from IDLE; returns just after the entry edge (dwell cycle 0 of index 0).
  task automatic startScan();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [7:0] expAddr,
                             input logic [3:0] expIdx, input logic expSample, input logic expDone);
    logic [14:0] obs, exp;
    obs = {addr_valid, address, index, sample, pass_done};
    exp = {expValid, expAddr, expIdx, expSample, expDone};
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed {valid,addr,idx,sample,done}=%h required %h", tag, obs, exp);
    end
  endtask

  task automatic checkVariant(input string tag, input logic expValid, input logic [7:0] expAddr,
                              input logic [2:0] expIdx, input logic expSample, input logic expDone);
    logic [13:0] obs, exp;
    obs = {addrValidV, addressV, indexV, sampleV, passDoneV};
    exp = {expValid, expAddr, expIdx, expSample, expDone};
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed {valid,addr,idx,sample,done}=%h required %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef RTC_SCAN_TRISTATE_EN
    idleAddr = 8'hzz;
`else
    idleAddr = 8'h00;
`endif
    scanList    = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
    variantList = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("reset", 1'b0, idleAddr, 4'd0, 1'b0, 1'b0);
    checkVariant("reset_var", 1'b0, idleAddr, 3'd0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;

    $display("[TB] continuous scan");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 2000; k++) begin
      int p;
      p = (k / 74) % 11;
      checkOutput("continuous", 1'b1, scanList[p], 4'(p), (k % 74) == 73, ((k % 74) == 73) && (p == 10));
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("rw_low_idle", 1'b0, idleAddr, 4'd0, 1'b0, 1'b0);

    $display("[TB] single pass");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 814; k++) begin
      int p;
      p = k / 74;
      checkOutput("single_pass", 1'b1, scanList[p], 4'(p), (k % 74) == 73, ((k % 74) == 73) && (p == 10));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      checkOutput("single_done", 1'b0, idleAddr, 4'd10, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("single_rw_low", 1'b0, idleAddr, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("single_restart", 1'b1, 8'h21, 4'd0, 1'b0, 1'b0);

    $display("[TB] pause at dwell count 30 of 8'h24");
    startScan();
    repeat (252) step();
    checkOutput("pause_pre", 1'b1, 8'h24, 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("pause_hold", 1'b1, 8'h24, 4'd3, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 43; i++) begin
      step();
      checkOutput("pause_tail", 1'b1, 8'h24, 4'd3, i == 42, 1'b0);
    end
    step();
    checkOutput("pause_next", 1'b1, 8'h25, 4'd4, 1'b0, 1'b0);

    $display("[TB] per_read gap at index 5");
    startScan();
    repeat (380) step();
    checkOutput("freeze_pre", 1'b1, 8'h26, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("freeze_gap", 1'b0, idleAddr, 4'd5, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 63; i++) begin
      step();
      checkOutput("freeze_resume", 1'b1, 8'h26, 4'd5, i == 62, 1'b0);
    end
    step();
    checkOutput("freeze_next", 1'b1, 8'h27, 4'd6, 1'b0, 1'b0);

    $display("[TB] rw drop at index 9");
    startScan();
    repeat (680) step();
    checkOutput("rw_pre", 1'b1, 8'h42, 4'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("rw_drop", 1'b0, idleAddr, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 74; i++) begin
      step();
      checkOutput("rw_restart", 1'b1, 8'h21, 4'd0, i == 73, 1'b0);
    end
    step();
    checkOutput("rw_restart_next", 1'b1, 8'h22, 4'd1, 1'b0, 1'b0);
    repeat (73) step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rw_drop_strobe", 1'b1, 8'h22, 4'd1, 1'b1, 1'b0);
    step();
    checkOutput("rw_drop_strobe_idle", 1'b0, idleAddr, 4'd0, 1'b0, 1'b0);

    $display("[TB] async reset at index 3");
    startScan();
    repeat (240) step();
    checkOutput("reset_pre", 1'b1, 8'h24, 4'd3, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, idleAddr, 4'd0, 1'b0, 1'b0);
    checkVariant("async_reset_var", 1'b0, idleAddr, 3'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    step();
    checkOutput("reset_restart", 1'b1, 8'h21, 4'd0, 1'b0, 1'b0);

    $display("[TB] variant FE..01 wrap, dwell 2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkVariant("var_idle", 1'b0, idleAddr, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      int p;
      p = (k / 2) % 4;
      checkVariant("variant", 1'b1, variantList[p], 3'(p), (k % 2) == 1, ((k % 2) == 1) && (p == 3));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
